// File: rtl/regfile_pkg.sv
// Shared types and helpers for the clearable 2-read/1-write register file.
package regfile_pkg;

    typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

    // Address width for an entry count; never narrower than one bit.
    function automatic int rf_addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/register_en_nb.sv
// Plain storage register with write enable and no reset; contents are
// initialised by the register file's clear engine instead.
module register_en_nb #(
    parameter int p_nbits = 8
) (
    input  logic               clk,
    input  logic               i_en,
    input  logic [p_nbits-1:0] i_d,
    output logic [p_nbits-1:0] o_q
);

    logic [p_nbits-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_en) r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/regfile_2r1w_clr.sv
// Register file with two combinational read ports, one write port, optional
// same-cycle write bypass and a one-entry-per-cycle hardware clear engine.
//
// state    | meaning
// RF_IDLE  | normal operation: writes accepted, reads return entries
// RF_CLEAR | walking r_ptr over all entries writing zero; busy, reads 0
module regfile_2r1w_clr
    import regfile_pkg::*;
#(
    parameter int p_nbits  = 8,
    parameter int p_nregs  = 8,
    parameter int p_bypass = 1,
    localparam int AW      = rf_addr_w(p_nregs)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    output logic               busy,
    input  logic               wen,
    input  logic [AW-1:0]      waddr,
    input  logic [p_nbits-1:0] wdata,
    input  logic [AW-1:0]      raddr0,
    output logic [p_nbits-1:0] rdata0,
    input  logic [AW-1:0]      raddr1,
    output logic [p_nbits-1:0] rdata1
);

    rf_state_t          r_state;
    rf_state_t          w_state_nxt;
    logic [AW-1:0]      r_ptr;
    logic [AW-1:0]      w_ptr_nxt;
    logic               w_clr_act;
    logic               w_wr_act;
    logic [p_nregs-1:0] w_en;
    logic [p_nbits-1:0] w_din [p_nregs];
    logic [p_nbits-1:0] w_q   [p_nregs];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RF_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            RF_IDLE: begin
                if (clear) begin
                    w_state_nxt = RF_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            RF_CLEAR: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == AW'(p_nregs - 1)) begin
                    w_state_nxt = RF_IDLE;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = RF_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // rst is folded in so busy and zeroed reads hold even before the first edge.
    assign busy      = rst || (r_state == RF_CLEAR);
    assign w_clr_act = !rst && (r_state == RF_CLEAR);
    assign w_wr_act  = !rst && (r_state == RF_IDLE) && !clear && wen;

    for (genvar i = 0; i < p_nregs; i++) begin : g_entry
        assign w_en[i]  = (w_clr_act && (r_ptr == AW'(i))) ||
                          (w_wr_act  && (waddr == AW'(i)));
        assign w_din[i] = w_clr_act ? '0 : wdata;

        register_en_nb #(.p_nbits(p_nbits)) u_reg (
            .clk  (clk),
            .i_en (w_en[i]),
            .i_d  (w_din[i]),
            .o_q  (w_q[i])
        );
    end

    always_comb begin
        rdata0 = '0;
        rdata1 = '0;
        if (!busy) begin
            rdata0 = w_q[raddr0];
            rdata1 = w_q[raddr1];
            if ((p_bypass != 0) && w_wr_act && (raddr0 == waddr)) rdata0 = wdata;
            if ((p_bypass != 0) && w_wr_act && (raddr1 == waddr)) rdata1 = wdata;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Directed bench for regfile_2r1w_clr: default bypass instance, a no-bypass
// instance and a 32-bit two-entry instance sharing clock and reset.
module tb_regfile_2r1w_clr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance (bypass on)
    logic       a_clear = 0, a_busy, a_wen = 0;
    logic [2:0] a_waddr = 0, a_raddr0 = 0, a_raddr1 = 0;
    logic [7:0] a_wdata = 0, a_rdata0, a_rdata1;

    // No-bypass instance
    logic       b_clear = 0, b_busy, b_wen = 0;
    logic [2:0] b_waddr = 0, b_raddr0 = 0, b_raddr1 = 0;
    logic [7:0] b_wdata = 0, b_rdata0, b_rdata1;

    // Wide, two-entry instance
    logic        c_clear = 0, c_busy, c_wen = 0;
    logic [0:0]  c_waddr = 0, c_raddr0 = 0, c_raddr1 = 0;
    logic [31:0] c_wdata = 0, c_rdata0, c_rdata1;

    regfile_2r1w_clr dut (
        .clk(clk), .rst(rst), .clear(a_clear), .busy(a_busy),
        .wen(a_wen), .waddr(a_waddr), .wdata(a_wdata),
        .raddr0(a_raddr0), .rdata0(a_rdata0),
        .raddr1(a_raddr1), .rdata1(a_rdata1)
    );

    regfile_2r1w_clr #(.p_bypass(0)) dut_nb (
        .clk(clk), .rst(rst), .clear(b_clear), .busy(b_busy),
        .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata),
        .raddr0(b_raddr0), .rdata0(b_rdata0),
        .raddr1(b_raddr1), .rdata1(b_rdata1)
    );

    regfile_2r1w_clr #(.p_nbits(32), .p_nregs(2)) dut_w (
        .clk(clk), .rst(rst), .clear(c_clear), .busy(c_busy),
        .wen(c_wen), .waddr(c_waddr), .wdata(c_wdata),
        .raddr0(c_raddr0), .rdata0(c_rdata0),
        .raddr1(c_raddr1), .rdata1(c_rdata1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cnt_a, cnt_b, cnt_c;
        rst = 1'b1;
        a_raddr0 = 3'd3;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b1 || a_rdata0 !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold busy=%b rdata0=%h want busy=1 rdata0=00", a_busy, a_rdata0);
        end
        tick();
        rst = 1'b0;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (a_busy) begin
                cnt_a++;
                checks++;
                if (a_rdata0 !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_walk_rdata0 got %h want 00", a_rdata0);
                end
            end
            if (b_busy) cnt_b++;
            if (c_busy) cnt_c++;
            tick();
        end
        checks++;
        if (cnt_a != 8) begin
            errors++;
            $display("FAIL reset_busy_len got %0d want 8", cnt_a);
        end
        checks++;
        if (cnt_b != 8) begin
            errors++;
            $display("FAIL reset_busy_len_nb got %0d want 8", cnt_b);
        end
        checks++;
        if (cnt_c != 2) begin
            errors++;
            $display("FAIL reset_busy_len_wide got %0d want 2", cnt_c);
        end
        for (int i = 0; i < 8; i++) begin
            a_raddr0 = 3'(i);
            #1;
            checks++;
            if (a_rdata0 !== 8'h00) begin
                errors++;
                $display("FAIL reset_contents addr %0d got %h want 00", i, a_rdata0);
            end
        end
    endtask

    task automatic test_write_read();
        a_wen = 1; a_waddr = 3'd2; a_wdata = 8'hA5;
        tick();
        a_waddr = 3'd7; a_wdata = 8'h3C;
        tick();
        a_wen = 0;
        a_raddr0 = 3'd2; a_raddr1 = 3'd7;
        @(negedge clk);
        checks++;
        if (a_rdata0 !== 8'hA5) begin
            errors++;
            $display("FAIL write_read_p0 got %h want a5", a_rdata0);
        end
        checks++;
        if (a_rdata1 !== 8'h3C) begin
            errors++;
            $display("FAIL write_read_p1 got %h want 3c", a_rdata1);
        end
        a_raddr1 = 3'd2;
        #1;
        checks++;
        if (a_rdata1 !== 8'hA5 || a_rdata0 !== 8'hA5) begin
            errors++;
            $display("FAIL same_addr_both got %h/%h want a5/a5", a_rdata0, a_rdata1);
        end
    endtask

    task automatic test_bypass();
        tick();
        a_wen = 1; a_waddr = 3'd5; a_wdata = 8'h11; a_raddr0 = 3'd5; a_raddr1 = 3'd5;
        b_wen = 1; b_waddr = 3'd5; b_wdata = 8'h11; b_raddr0 = 3'd5; b_raddr1 = 3'd5;
        @(negedge clk);
        checks++;
        if (a_rdata0 !== 8'h11 || a_rdata1 !== 8'h11) begin
            errors++;
            $display("FAIL bypass_on got %h/%h want 11/11", a_rdata0, a_rdata1);
        end
        checks++;
        if (b_rdata0 !== 8'h00 || b_rdata1 !== 8'h00) begin
            errors++;
            $display("FAIL bypass_off_same_cycle got %h/%h want 00/00", b_rdata0, b_rdata1);
        end
        a_raddr1 = 3'd6;
        #1;
        checks++;
        if (a_rdata0 !== 8'h11 || a_rdata1 !== 8'h00) begin
            errors++;
            $display("FAIL bypass_indep got %h/%h want 11/00", a_rdata0, a_rdata1);
        end
        tick();
        a_wen = 0; b_wen = 0; a_raddr1 = 3'd5;
        @(negedge clk);
        checks++;
        if (b_rdata0 !== 8'h11 || b_rdata1 !== 8'h11) begin
            errors++;
            $display("FAIL bypass_off_next got %h/%h want 11/11", b_rdata0, b_rdata1);
        end
        checks++;
        if (a_rdata0 !== 8'h11 || a_rdata1 !== 8'h11) begin
            errors++;
            $display("FAIL bypass_on_stored got %h/%h want 11/11", a_rdata0, a_rdata1);
        end
    endtask

    task automatic fill(input logic [7:0] val);
        for (int i = 0; i < 8; i++) begin
            a_wen = 1; a_waddr = 3'(i); a_wdata = val;
            tick();
        end
        a_wen = 0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            a_raddr0 = 3'(i);
            #1;
            checks++;
            if (a_rdata0 !== 8'h00) begin
                errors++;
                $display("FAIL %s addr %0d got %h want 00", tag, i, a_rdata0);
            end
        end
    endtask

    task automatic test_clear_vs_write();
        int cnt;
        fill(8'hFF);
        a_raddr0 = 3'd1;
        a_clear = 1; a_wen = 1; a_waddr = 3'd1; a_wdata = 8'h42;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_rdata0 !== 8'hFF) begin
            errors++;
            $display("FAIL clear_req_cycle busy=%b rdata0=%h want 0/ff", a_busy, a_rdata0);
        end
        tick();
        a_clear = 0; a_wen = 0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!a_busy) break;
            cnt++;
            checks++;
            if (a_rdata0 !== 8'h00) begin
                errors++;
                $display("FAIL clear_forced_zero got %h want 00", a_rdata0);
            end
            tick();
            a_clear = (cnt == 2 || cnt == 5);
            a_wen   = (cnt == 2 || cnt == 5);
            a_waddr = 3'd3; a_wdata = 8'h77;
        end
        a_clear = 0; a_wen = 0;
        checks++;
        if (cnt != 8) begin
            errors++;
            $display("FAIL clear_busy_len got %0d want 8", cnt);
        end
        check_all_zero("clear_contents");
    endtask

    task automatic test_reset_mid();
        int cnt;
        tick();
        fill(8'h5A);
        a_clear = 1;
        tick();
        a_clear = 0;
        for (int k = 0; k < 3; k++) tick();
        rst = 1;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b1 || a_rdata0 !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_hold busy=%b rdata0=%h want 1/00", a_busy, a_rdata0);
        end
        tick();
        rst = 0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!a_busy) break;
            cnt++;
            tick();
        end
        checks++;
        if (cnt != 8) begin
            errors++;
            $display("FAIL rst_mid_busy_len got %0d want 8", cnt);
        end
        check_all_zero("rst_mid_contents");
    endtask

    task automatic test_param();
        c_wen = 1; c_waddr = 1'b1; c_wdata = 32'hDEADBEEF;
        tick();
        c_wen = 0; c_raddr0 = 1'b1; c_raddr1 = 1'b1;
        @(negedge clk);
        checks++;
        if (c_rdata0 !== 32'hDEADBEEF || c_rdata1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wide_readback got %h/%h want deadbeef", c_rdata0, c_rdata1);
        end
        c_raddr0 = 1'b0;
        #1;
        checks++;
        if (c_rdata0 !== 32'h0) begin
            errors++;
            $display("FAIL wide_other_entry got %h want 00000000", c_rdata0);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_clear_vs_write();
        test_reset_mid();
        test_param();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
